enigma_group_tx: RTL and testbench

//  Consumer end of the enigma output interface (out_char/out_char_ready). Buffers

---
 rtl/enigma_pkg.sv | 27 ++
 rtl/enigma_sync_fifo.sv | 70 +++++++
 rtl/enigma_group_tx.sv | 177 +++++++++++++++++
 tb/tb_enigma_group_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// ----------------------------------------------------------------------------
// enigma_pkg
// Shared definitions for the enigma output path:
//   - ASCII control characters used when framing cipher text for a terminal
//   - FSM state encoding of the group transmitter
//   - cnt_w(): width of a counter that must hold 0..n-1 (never narrower than 1)
// ----------------------------------------------------------------------------
package enigma_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAITB = 3'd3,
    ST_LF    = 3'd4
  } grp_state_t;

  // A modulo-n counter needs $clog2(n) bits; n==1 still needs a 1-bit vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enigma_sync_fifo.sv
// ----------------------------------------------------------------------------
// enigma_sync_fifo
// Single-clock FIFO with first-word-fall-through head: the oldest entry is
// always visible on 'head' while 'empty' is low, and 'pop' simply advances.
//   clk    in   system clock
//   rset   in   synchronous active-high reset (pointers and level only)
//   push   in   write request; ignored while full
//   wdata  in   WIDTH-bit write data
//   pop    in   read-advance request; ignored while empty
//   head   out  oldest entry (valid while !empty)
//   full   out  level == 2**FIFO_AW
//   empty  out  level == 0
//   level  out  number of entries, FIFO_AW+1 bits
// Full/empty are the registered state of the current cycle, so a push while
// full is dropped even if a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module enigma_sync_fifo #(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               rset,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int              DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign full    = (cnt == FULL_LVL);
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign head    = mem[rptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries data only; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/enigma_group_tx.sv
// ----------------------------------------------------------------------------
// enigma_group_tx
// Consumer end of the enigma output strobe. Buffers cipher characters and
// hands them one at a time to a busy-flagged byte transmitter, framed as
// classic 5-letter groups: "ABCDE FGHIJ ...", CR LF after GROUPS_PER_LINE
// groups.
//   clk          in   system clock
//   rset         in   synchronous active-high reset
//   in_char      in   8-bit cipher character
//   in_char_rdy  in   1-cycle write strobe for in_char
//   flush        in   1-cycle request to terminate the current line
//   tx_busy      in   transmitter busy
//   tx_data      out  byte for the transmitter, held between starts
//   tx_start     out  1-cycle start pulse to the transmitter
//   fifo_level   out  characters currently buffered
//   overflow     out  sticky: a character was dropped because the FIFO was full
//   idle         out  FIFO empty, FSM idle and no flush pending
// ----------------------------------------------------------------------------
module enigma_group_tx
  import enigma_pkg::*;
#(
  parameter int         FIFO_AW         = 4,
  parameter int         GROUP_LEN       = 5,
  parameter int         GROUPS_PER_LINE = 5,
  parameter logic [7:0] SEP_CHAR        = 8'h20
) (
  input  logic               clk,
  input  logic               rset,
  input  logic [7:0]         in_char,
  input  logic               in_char_rdy,
  input  logic               flush,
  input  logic               tx_busy,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               idle
);

  localparam int CCW = cnt_w(GROUP_LEN);
  localparam int GCW = cnt_w(GROUPS_PER_LINE);
  localparam logic [CCW-1:0] CC_LAST = CCW'(GROUP_LEN - 1);
  localparam logic [GCW-1:0] GC_LAST = GCW'(GROUPS_PER_LINE - 1);

  grp_state_t     state;
  logic [CCW-1:0] ccnt;
  logic [GCW-1:0] gcnt;
  logic           sep_due;
  logic           flush_pend;
  logic           last_cr;

  logic [7:0]     fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_pop;

  logic           can_issue;
  logic           sep_go;
  logic           data_go;
  logic           flush_go;
  logic           flush_nop;
  logic           partial;

  enigma_sync_fifo #(
    .WIDTH   (8),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rset  (rset),
    .push  (in_char_rdy),
    .wdata (in_char),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A line is "open" when anything has been sent since the last CR LF,
  // including a completed group whose separator is still owed.
  assign partial   = (ccnt != '0) || (gcnt != '0) || sep_due;
  assign can_issue = (state == ST_IDLE) && !tx_busy;

  // The separator is owed after a full group but only goes out once the next
  // data character is already buffered, so a line never ends in a space.
  assign sep_go    = can_issue && sep_due && !fifo_empty;
  assign data_go   = can_issue && !sep_due && !fifo_empty;
  assign flush_go  = can_issue && flush_pend && fifo_empty && partial;
  assign flush_nop = (state == ST_IDLE) && flush_pend && fifo_empty && !partial;
  assign fifo_pop  = data_go;

  assign idle = fifo_empty && (state == ST_IDLE) && !flush_pend;

  always_ff @(posedge clk) begin
    if (rset) begin
      state      <= ST_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      ccnt       <= '0;
      gcnt       <= '0;
      sep_due    <= 1'b0;
      flush_pend <= 1'b0;
      last_cr    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      tx_start <= 1'b0;

      // Full is sampled before this cycle's pop: a write into a full FIFO is lost.
      if (in_char_rdy && fifo_full) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (sep_go) begin
            tx_start <= 1'b1;
            state    <= ST_SEND;
            sep_due  <= 1'b0;
            if (gcnt == GC_LAST) begin
              tx_data <= ASCII_CR;
              gcnt    <= '0;
              last_cr <= 1'b1;
            end else begin
              tx_data <= SEP_CHAR;
              gcnt    <= gcnt + 1'b1;
              last_cr <= 1'b0;
            end
          end else if (data_go) begin
            tx_start <= 1'b1;
            tx_data  <= fifo_head;
            state    <= ST_SEND;
            last_cr  <= 1'b0;
            if (ccnt == CC_LAST) begin
              ccnt    <= '0;
              sep_due <= 1'b1;
            end else begin
              ccnt <= ccnt + 1'b1;
            end
          end else if (flush_go) begin
            tx_start <= 1'b1;
            tx_data  <= ASCII_CR;
            state    <= ST_SEND;
            last_cr  <= 1'b1;
            sep_due  <= 1'b0;
          end else if (flush_nop) begin
            flush_pend <= 1'b0;
          end
        end

        // tx_start is high during this state.
        ST_SEND: state <= ST_GUARD;

        // The transmitter may take a cycle to raise busy; ignore it here.
        ST_GUARD: state <= ST_WAITB;

        ST_WAITB: begin
          if (!tx_busy) state <= last_cr ? ST_LF : ST_IDLE;
        end

        // Every CR is followed by LF; the line is then closed.
        ST_LF: begin
          tx_start   <= 1'b1;
          tx_data    <= ASCII_LF;
          state      <= ST_SEND;
          last_cr    <= 1'b0;
          ccnt       <= '0;
          gcnt       <= '0;
          flush_pend <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase

      // A new flush request wins over a same-cycle clear of the old one.
      if (flush) flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enigma_group_tx.sv
// ----------------------------------------------------------------------------
// tb_enigma_group_tx
// Directed bench for enigma_group_tx with a byte-level scoreboard. Expected
// transmitter bytes are queued as stimulus is applied; every tx_start pops
// one and compares. A small transmitter model raises tx_busy for 10 cycles
// after each start and can be held busy by the stimulus.
// ----------------------------------------------------------------------------
module tb_enigma_group_tx;

  logic       clk = 1'b0;
  logic       rset;
  logic [7:0] in_char;
  logic       in_char_rdy;
  logic       flush;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       idle;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         tx_cnt = 0;
  int         cyc = 0;
  int         last_start = -100;
  int         busy_cnt = 0;
  logic       busy_hold = 1'b0;
  int         snap;

  always #5 clk = ~clk;

  assign tx_busy = busy_hold || (busy_cnt != 0);

  enigma_group_tx dut (
    .clk         (clk),
    .rset        (rset),
    .in_char     (in_char),
    .in_char_rdy (in_char_rdy),
    .flush       (flush),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .idle        (idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model and scoreboard, both sampling on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_start === 1'b1) begin
      chk("tx_gap_ge3", 32'((cyc - last_start) >= 3), 32'd1);
      chk("tx_data", {24'd0, tx_data},
          (sb.size() != 0) ? {24'd0, sb.pop_front()} : 32'h100);
      last_start <= cyc;
      tx_cnt     <= tx_cnt + 1;
      busy_cnt   <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
  endtask

  task automatic push_crlf();
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic strobe(input logic [7:0] c);
    in_char     = c;
    in_char_rdy = 1'b1;
    @(negedge clk);
    in_char_rdy = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (sb.size() == 0 && idle === 1'b1 && tx_busy == 1'b0) break;
      @(negedge clk);
    end
    chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rset        = 1'b1;
    in_char     = 8'h00;
    in_char_rdy = 1'b0;
    flush       = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    rset = 1'b0;
    @(negedge clk);

    // "ABCDEFGHIJK" -> "ABCDE FGHIJ K", then flush -> CR LF
    push_str("ABCDE FGHIJ K");
    for (int i = 0; i < 11; i++) begin
      strobe(8'(8'h41 + i));
      if (i == 0) begin
        chk("latency_early", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        chk("latency_2cyc", {31'd0, tx_start}, 32'd1);
        repeat (14) @(negedge clk);
      end else begin
        repeat (15) @(negedge clk);
      end
    end
    wait_drain("t2");
    push_crlf();
    pulse_flush();
    wait_drain("t2_flush");

    // 25 chars fill a line; the line end waits for the 26th char
    push_str("ABCDE FGHIJ KLMNO PQRST UVWXY");
    for (int i = 0; i < 25; i++) begin
      strobe(8'(8'h41 + i));
      repeat (15) @(negedge clk);
    end
    wait_drain("t3");
    snap = tx_cnt;
    repeat (60) @(negedge clk);
    chk("t3_no_trailing", tx_cnt, snap);
    push_crlf();
    push_str("Z");
    strobe(8'h5A);
    wait_drain("t3_z");
    push_crlf();
    pulse_flush();
    wait_drain("t3_flush");

    // Overflow: 17 strobes into a held transmitter
    busy_hold = 1'b1;
    push_str("abcde fghij klmno p");
    for (int i = 0; i < 16; i++) strobe(8'(8'h61 + i));
    chk("t4_level16", {27'd0, fifo_level}, 32'd16);
    chk("t4_no_ovf_yet", {31'd0, overflow}, 32'd0);
    strobe(8'h71);
    chk("t4_level_still16", {27'd0, fifo_level}, 32'd16);
    chk("t4_overflow", {31'd0, overflow}, 32'd1);
    busy_hold = 1'b0;
    wait_drain("t4");
    push_crlf();
    pulse_flush();
    wait_drain("t4_flush");

    // Simultaneous push and pop at level 3
    busy_hold = 1'b1;
    push_str("abcd");
    strobe(8'h61);
    strobe(8'h62);
    strobe(8'h63);
    chk("t5_level3", {27'd0, fifo_level}, 32'd3);
    busy_hold = 1'b0;
    strobe(8'h64);
    chk("t5_push_pop_level", {27'd0, fifo_level}, 32'd3);
    wait_drain("t5");
    push_crlf();
    pulse_flush();
    wait_drain("t5_flush");

    // Reset while waiting on the transmitter with 4 chars buffered
    push_str("V");
    for (int i = 0; i < 5; i++) strobe(8'(8'h56 + i));
    chk("t6_level4", {27'd0, fifo_level}, 32'd4);
    rset = 1'b1;
    @(negedge clk);
    rset = 1'b0;
    chk("t6_idle", {31'd0, idle}, 32'd1);
    chk("t6_level0", {27'd0, fifo_level}, 32'd0);
    chk("t6_overflow_clr", {31'd0, overflow}, 32'd0);
    chk("t6_tx_start", {31'd0, tx_start}, 32'd0);
    snap = tx_cnt;
    repeat (40) @(negedge clk);
    chk("t6_no_more_tx", tx_cnt, snap);
    push_str("ABCDE F");
    for (int i = 0; i < 6; i++) begin
      strobe(8'(8'h41 + i));
      repeat (15) @(negedge clk);
    end
    wait_drain("t6");
    push_crlf();
    pulse_flush();
    wait_drain("t6_flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
